// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for decoder_scan and its helpers:
//   MODE_DIRECT / MODE_SCAN : values of the mode input
//   state_t                 : IDLE / DIRECT / SCAN state encoding (2 bits)
//   onehot_dec()            : index -> one-hot line vector with polarity applied
package decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest index the shared decode function supports.
   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT   = 2 ** MAX_SEL_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   // Returns a MAX_OUT-wide vector; callers size-cast it down to their own
   // output count. With active_low set, the selected line is the only 0.
   function automatic logic [MAX_OUT-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] index,
                                                     input logic active_low);
      logic [MAX_OUT-1:0] v;
      v        = '0;
      v[index] = 1'b1;
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// decoder_scan_if
// Control and line bundle of decoder_scan.
//   en, mode, sel : driven by the controlling logic (master)
//   y, idx, wrap  : registered decoder outputs (slave drives them)
interface decoder_scan_if #(
   parameter int SEL_W = 3
);
   localparam int OUT_N = 2 ** SEL_W;

   logic             en;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [OUT_N-1:0] y;
   logic [SEL_W-1:0] idx;
   logic             wrap;

   modport master (output en, mode, sel, input y, idx, wrap);
   modport slave  (input en, mode, sel, output y, idx, wrap);
endinterface

// File: rtl/tick_div.sv
// tick_div
// Prescaler counting 0..DIV-1. tick pulses for one clock while the count
// sits at DIV-1; the count then wraps to 0. clr forces the count to 0 and
// suppresses tick in the same cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear
//   tick  : terminal-count pulse
module tick_div #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             at_last;

   assign at_last = (cnt_reg == CNT_LAST);
   assign tick    = at_last && !clr;

   always_comb begin
      cnt_next = cnt_reg + 1'b1;
      if (clr || at_last) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan
// Registered N-to-2^N line decoder with selectable polarity and an
// auto-scan mode that walks one active line across 0..SCAN_LAST, dwelling
// SCAN_DIV clocks on each.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (synchronous release upstream)
//   bus.en   : 0 forces all lines inactive
//   bus.mode : MODE_DIRECT decodes bus.sel, MODE_SCAN auto-scans
//   bus.sel  : index decoded in direct mode
//   bus.y    : decoded lines (registered)
//   bus.idx  : index currently shown on y
//   bus.wrap : one-clock pulse when the scan returns from SCAN_LAST to 0
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int ACTIVE_LOW = 1,
   parameter int SCAN_DIV   = 50000,
   parameter int SCAN_LAST  = 2 ** SEL_W - 1
) (
   input logic           clk,
   input logic           rst_n,
   decoder_scan_if.slave bus
);
   localparam int OUT_N = 2 ** SEL_W;
   localparam logic [OUT_N-1:0] Y_IDLE   = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(SCAN_LAST);
   localparam logic             POL_LOW  = (ACTIVE_LOW != 0);

   // Parameter sanity: stop elaboration on settings that cannot work.
   if (SCAN_DIV < 1) begin : g_bad_div
      $fatal(1, "decoder_scan: SCAN_DIV must be >= 1");
   end
   if (SCAN_LAST < 0 || SCAN_LAST > OUT_N - 1) begin : g_bad_last
      $fatal(1, "decoder_scan: SCAN_LAST must be within 0..OUT_N-1");
   end
   if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
      $fatal(1, "decoder_scan: SEL_W out of supported range");
   end

   state_t           state_reg;
   state_t           state_next;
   logic [SEL_W-1:0] idx_reg;
   logic [SEL_W-1:0] idx_next;
   logic [OUT_N-1:0] y_reg;
   logic [OUT_N-1:0] y_next;
   logic             wrap_reg;
   logic             wrap_next;
   logic             presc_clr;
   logic             presc_tick;

   tick_div #(
      .DIV (SCAN_DIV)
   ) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (presc_clr),
      .tick  (presc_tick)
   );

   always_comb begin
      state_next = ST_IDLE;
      idx_next   = idx_reg;
      wrap_next  = 1'b0;
      presc_clr  = 1'b1;
      y_next     = Y_IDLE;

      if (bus.en) begin
         state_next = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      end

      case (state_next)
         ST_DIRECT: begin
            idx_next = bus.sel;
         end
         ST_SCAN: begin
            if (state_reg != ST_SCAN) begin
               // Entering scan (from idle or direct) always restarts at line 0
               // with a fresh dwell; the prescaler stays cleared this cycle.
               idx_next = '0;
            end else begin
               presc_clr = 1'b0;
               if (presc_tick) begin
                  if (idx_reg == LAST_IDX) begin
                     idx_next  = '0;
                     wrap_next = 1'b1;
                  end else begin
                     idx_next = idx_reg + 1'b1;
                  end
               end
            end
         end
         default: begin
         end
      endcase

      // Lines are derived from the next index so y and idx update together.
      if (state_next != ST_IDLE) begin
         y_next = OUT_N'(onehot_dec(MAX_SEL_W'(idx_next), POL_LOW));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         y_reg     <= Y_IDLE;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         y_reg     <= y_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign bus.y    = y_reg;
   assign bus.idx  = idx_reg;
   assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan
// Scoreboard bench for decoder_scan. Three instances share clk/rst_n:
//   A: SEL_W=3, active-low, SCAN_DIV=4, SCAN_LAST=5
//   B: SEL_W=4, active-high, SCAN_DIV=1, SCAN_LAST=0
//   C: SEL_W=3, active-low, SCAN_DIV=1, SCAN_LAST=7
// Stimulus pushes the expected outputs after each posedge into a queue; a
// monitor pops and compares them 1 ns after that edge.
module tb_decoder_scan;

   logic clk;
   logic rst_n;

   decoder_scan_if #(.SEL_W(3)) bus_a ();
   decoder_scan_if #(.SEL_W(4)) bus_b ();
   decoder_scan_if #(.SEL_W(3)) bus_c ();

   decoder_scan #(.SEL_W(3), .ACTIVE_LOW(1), .SCAN_DIV(4), .SCAN_LAST(5)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );
   decoder_scan #(.SEL_W(4), .ACTIVE_LOW(0), .SCAN_DIV(1), .SCAN_LAST(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );
   decoder_scan #(.SEL_W(3), .ACTIVE_LOW(1), .SCAN_DIV(1), .SCAN_LAST(7)) dut_c (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_c)
   );

   typedef struct {
      int          dut;
      logic [15:0] y;
      logic [3:0]  idx;
      logic        wrap;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Direct-mode one-cold codes for SEL_W=3, active-low.
   logic [7:0] direct_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] actual_y(int dut);
      case (dut)
         0:       return {8'h00, bus_a.y};
         1:       return bus_b.y;
         default: return {8'h00, bus_c.y};
      endcase
   endfunction

   function automatic logic [3:0] actual_idx(int dut);
      case (dut)
         0:       return {1'b0, bus_a.idx};
         1:       return bus_b.idx;
         default: return {1'b0, bus_c.idx};
      endcase
   endfunction

   function automatic logic actual_wrap(int dut);
      case (dut)
         0:       return bus_a.wrap;
         1:       return bus_b.wrap;
         default: return bus_c.wrap;
      endcase
   endfunction

   function automatic logic [7:0] cold8(int i);
      logic [7:0] v;
      v = 8'h01 << i;
      return ~v;
   endfunction

   task automatic push(int dut, logic [15:0] y, logic [3:0] idx, logic wrap, string tag);
      exp_t e;
      e.dut  = dut;
      e.y    = y;
      e.idx  = idx;
      e.wrap = wrap;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Immediate check used where the event is asynchronous (reset).
   task automatic check_now(int dut, logic [15:0] y, logic [3:0] idx, logic wrap, string tag);
      logic [15:0] ay;
      logic [3:0]  ai;
      logic        aw;
      ay = actual_y(dut);
      ai = actual_idx(dut);
      aw = actual_wrap(dut);
      checks++;
      if (ay !== y || ai !== idx || aw !== wrap) begin
         errors++;
         $display("FAIL %s dut%0d: got y=%h idx=%0d wrap=%b, want y=%h idx=%0d wrap=%b",
                  tag, dut, ay, ai, aw, y, idx, wrap);
      end else begin
         $display("ok   %s dut%0d y=%h idx=%0d wrap=%b", tag, dut, ay, ai, aw);
      end
   endtask

   // Monitor: consumes every expectation pushed before this edge.
   always @(posedge clk) begin
      #1;
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if (actual_y(mon_e.dut) !== mon_e.y || actual_idx(mon_e.dut) !== mon_e.idx ||
             actual_wrap(mon_e.dut) !== mon_e.wrap) begin
            errors++;
            $display("FAIL %s dut%0d: got y=%h idx=%0d wrap=%b, want y=%h idx=%0d wrap=%b",
                     mon_e.tag, mon_e.dut, actual_y(mon_e.dut), actual_idx(mon_e.dut),
                     actual_wrap(mon_e.dut), mon_e.y, mon_e.idx, mon_e.wrap);
         end else begin
            $display("ok   %s dut%0d y=%h idx=%0d wrap=%b", mon_e.tag, mon_e.dut,
                     mon_e.y, mon_e.idx, mon_e.wrap);
         end
      end
   end

   initial begin
      int ia;
      rst_n = 1'b0;
      bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.sel = '0;
      bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.sel = '0;
      bus_c.en = 1'b0; bus_c.mode = 1'b0; bus_c.sel = '0;

      // Reset state and polarity, sampled across a clock edge while held.
      #12;
      check_now(0, 16'h00FF, 4'd0, 1'b0, "reset_a");
      check_now(1, 16'h0000, 4'd0, 1'b0, "reset_b");
      check_now(2, 16'h00FF, 4'd0, 1'b0, "reset_c");
      @(negedge clk);
      rst_n = 1'b1;

      // Direct sweep: A over 8 codes, B over 16 active-high codes.
      for (int s = 0; s < 16; s++) begin
         @(negedge clk);
         bus_b.en = 1'b1; bus_b.mode = 1'b0; bus_b.sel = 4'(s);
         push(1, 16'(32'd1 << s), 4'(s), 1'b0, "direct_b");
         if (s < 8) begin
            bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.sel = 3'(s);
            push(0, {8'h00, direct_tbl[s]}, 4'(s), 1'b0, "direct_a");
         end
      end

      // Scan cadence. A: 4 clocks per index over 0..5, wrap every 24 clocks.
      // B: SCAN_LAST=0 so idx stays 0 and wrap fires every clock after entry.
      // C: SCAN_DIV=1 so idx advances every clock.
      for (int t = 0; t < 62; t++) begin
         @(negedge clk);
         bus_a.en = 1'b1; bus_a.mode = 1'b1;
         ia = (t / 4) % 6;
         push(0, {8'h00, cold8(ia)}, 4'(ia), (t > 0 && t % 24 == 0), "scan_a");
         if (t < 20) begin
            bus_b.en = 1'b1; bus_b.mode = 1'b1;
            bus_c.en = 1'b1; bus_c.mode = 1'b1;
            push(1, 16'h0001, 4'd0, (t > 0), "scan_b_last0");
            push(2, {8'h00, cold8(t % 8)}, 4'(t % 8), (t > 0 && t % 8 == 0), "scan_c_div1");
         end else begin
            bus_b.en = 1'b0;
            bus_c.en = 1'b0;
         end
      end

      // A is at idx 3 here; switch to direct with sel=6.
      @(negedge clk);
      bus_a.mode = 1'b0; bus_a.sel = 3'd6;
      push(0, 16'h00BF, 4'd6, 1'b0, "scan_to_direct");
      @(negedge clk);
      bus_a.en = 1'b0;
      push(0, 16'h00FF, 4'd6, 1'b0, "en_low");
      @(negedge clk);
      push(0, 16'h00FF, 4'd6, 1'b0, "idle_hold");

      // Re-enable in scan: restart at 0 with a full dwell.
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         bus_a.en = 1'b1; bus_a.mode = 1'b1;
         push(0, {8'h00, cold8(t / 4)}, 4'(t / 4), 1'b0, "scan_restart");
      end

      // Asynchronous reset between edges, mid-dwell on idx 1.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_now(0, 16'h00FF, 4'd0, 1'b0, "async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 10; t++) begin
         if (t != 0) @(negedge clk);
         push(0, {8'h00, cold8(t / 4)}, 4'(t / 4), 1'b0, "scan_after_reset");
      end

      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
